// File: rtl/ehl_rst_ctrl_pkg.sv
// Shared constants for the reset controller: CSR offsets, software reset key,
// CAUSE bit positions and FSM state encoding.
package ehl_rst_ctrl_pkg;

    localparam logic [4:0] CSR_CAUSE  = 5'h00;
    localparam logic [4:0] CSR_SWRST  = 5'h04;
    localparam logic [4:0] CSR_RSTCNT = 5'h08;

    localparam logic [7:0] SWRST_KEY = 8'hA5;

    localparam int unsigned CAUSE_POR = 0;
    localparam int unsigned CAUSE_WDT = 1;
    localparam int unsigned CAUSE_SW  = 2;
    localparam int unsigned CAUSE_EXT = 3;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ehl_rst_ctrl_if.sv
// Register bus shared with the timer blocks: write/read strobes, word address,
// write data and combinational read data.
interface ehl_rst_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             wr;
    logic             rd;
    logic [4:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;

    modport master (output wr, rd, addr, wdata, input rdata);
    modport slave  (input wr, rd, addr, wdata, output rdata);
endinterface

// File: rtl/ehl_rst_sync.sv
// Two-flop synchroniser with asynchronous assert (output low) and synchronous
// deassert; used both for the power-on reset and for the external reset pin.
module ehl_rst_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ehl_rst_ctrl.sv
// Reset controller downstream of the watchdog: generates the watchdog and
// stretched system resets and exposes reset cause / count CSRs.
module ehl_rst_ctrl
    import ehl_rst_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned STRETCH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           wdt_rst_req,
    input  logic           ext_rst_n,
    output logic           wdt_reset_n,
    output logic           sys_reset_n,
    ehl_rst_ctrl_if.slave  bus
);

    if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
        $fatal(1, "ehl_rst_ctrl: WIDTH must be 8, 16 or 32");
    end
    if (STRETCH < 2 || STRETCH > 65535) begin : g_bad_stretch
        $fatal(1, "ehl_rst_ctrl: STRETCH must be in 2..65535");
    end

    localparam logic [15:0] RELOAD = 16'(STRETCH - 1);

    logic        ext_sync;
    logic        ext_req;
    logic        sw_req;
    logic [3:0]  cause_set;
    logic [3:0]  cause_clr;
    logic [3:0]  cause;
    logic [7:0]  rstcnt;
    logic        rstcnt_wr;
    logic        any_req;
    logic        enter_hold;
    logic [1:0]  lane;
    logic [2:0]  word;
    logic [4:0]  word_addr;
    logic [31:0] rword;
    logic        unused_bits;
    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;

    ehl_rst_sync u_wdt_sync (.clk(clk), .rst_n(reset_n), .d(1'b1),      .q(wdt_reset_n));
    ehl_rst_sync u_ext_sync (.clk(clk), .rst_n(reset_n), .d(ext_rst_n), .q(ext_sync));

    assign ext_req = !ext_sync;

    // Sub-word buses: addr[1:0] picks the byte/halfword lane; byte 0 is only
    // written when lane 0 is addressed.
    always_comb begin
        word      = bus.addr[4:2];
        word_addr = {word, 2'b00};
        lane      = '0;
        if (WIDTH == 8) begin
            lane = bus.addr[1:0];
        end else if (WIDTH == 16) begin
            lane = {bus.addr[1], 1'b0};
        end
    end

    assign unused_bits = ^{bus.addr[1:0], bus.wdata};

    assign sw_req    = bus.wr && (word_addr == CSR_SWRST) && (lane == 2'd0)
                       && (bus.wdata[7:0] == SWRST_KEY);
    assign cause_clr = (bus.wr && (word_addr == CSR_CAUSE) && (lane == 2'd0))
                       ? bus.wdata[3:0] : '0;
    assign rstcnt_wr = bus.wr && (word_addr == CSR_RSTCNT);

    // Requests are ignored while the watchdog reset is still asserted, so the
    // pin synchroniser's reset value does not show up as an EXT cause.
    always_comb begin
        cause_set            = '0;
        cause_set[CAUSE_WDT] = wdt_reset_n & wdt_rst_req;
        cause_set[CAUSE_SW]  = wdt_reset_n & sw_req;
        cause_set[CAUSE_EXT] = wdt_reset_n & ext_req;
    end

    assign any_req    = |cause_set;
    assign enter_hold = (state == RUN) && any_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= HOLD;
            cnt         <= RELOAD;
            sys_reset_n <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sys_reset_n <= (state_nx == RUN);
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            HOLD: begin
                if (any_req) begin
                    cnt_nx = RELOAD;
                end else if (wdt_reset_n) begin
                    if (cnt == '0) begin
                        state_nx = RUN;
                    end else begin
                        cnt_nx = cnt - 16'd1;
                    end
                end
            end
            RUN: begin
                if (any_req) begin
                    state_nx = HOLD;
                    cnt_nx   = RELOAD;
                end
            end
            default: state_nx = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause  <= 4'b0001;
            rstcnt <= '0;
        end else begin
            cause <= (cause & ~cause_clr) | cause_set;
            if (rstcnt_wr) begin
                rstcnt <= enter_hold ? 8'd1 : 8'd0;
            end else if (enter_hold && (rstcnt != '1)) begin
                rstcnt <= rstcnt + 8'd1;
            end
        end
    end

    always_comb begin
        rword = '0;
        case (word_addr)
            CSR_CAUSE:  rword = {28'b0, cause};
            CSR_RSTCNT: rword = {24'b0, rstcnt};
            default:    rword = '0;
        endcase
        bus.rdata = bus.rd ? WIDTH'(rword >> {lane, 3'b000}) : '0;
    end

endmodule

// File: tb/tb_ehl_rst_ctrl.sv
// Directed plus randomised checks of ehl_rst_ctrl against a release-time model
// of the system reset and a bitwise model of the CSRs.
module tb_ehl_rst_ctrl;

    localparam int ST  = 16;
    localparam int ST8 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, wdt_req, ext_n, wdt_rn, sys_rn;
    logic wdt8, ext8, wdt_rn8, sys_rn8;

    ehl_rst_ctrl_if #(.WIDTH(32)) bus32 ();
    ehl_rst_ctrl_if #(.WIDTH(8))  bus8 ();

    ehl_rst_ctrl #(.WIDTH(32), .STRETCH(ST)) u32 (
        .clk(clk), .reset_n(reset_n), .wdt_rst_req(wdt_req), .ext_rst_n(ext_n),
        .wdt_reset_n(wdt_rn), .sys_reset_n(sys_rn), .bus(bus32)
    );

    ehl_rst_ctrl #(.WIDTH(8), .STRETCH(ST8)) u8 (
        .clk(clk), .reset_n(reset_n), .wdt_rst_req(wdt8), .ext_rst_n(ext8),
        .wdt_reset_n(wdt_rn8), .sys_reset_n(sys_rn8), .bus(bus8)
    );

    int total = 0;
    int bad   = 0;

    // Model: system reset is high once ST edges have elapsed since the last
    // request edge; power-on behaves like a request at the wdt release edge.
    int         n;
    int         last_req;
    logic [3:0] m_cause;
    int         m_rstcnt;
    logic       m_sys;
    logic       ext_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n          = 0;
        last_req   = 2;
        m_cause    = 4'b0001;
        m_rstcnt   = 0;
        m_sys      = 1'b0;
        ext_hist   = {1'b0, 1'b0};
    endtask

    task automatic step();
        logic       ext_req_m, sw_m, req, inc, act;
        logic [3:0] set, clr;
        @(posedge clk);
        n++;
        act       = (n >= 3);
        ext_req_m = !ext_hist.pop_front();
        ext_hist.push_back(ext_n);
        sw_m = bus32.wr && (bus32.addr[4:2] == 3'd1) && (bus32.wdata[7:0] == 8'hA5);
        set  = act ? {ext_req_m, sw_m, wdt_req, 1'b0} : 4'b0000;
        clr  = (bus32.wr && bus32.addr[4:2] == 3'd0) ? bus32.wdata[3:0] : 4'b0000;
        req  = |set;
        inc  = req && m_sys;
        if (bus32.wr && bus32.addr[4:2] == 3'd2) m_rstcnt = inc ? 1 : 0;
        else if (inc && m_rstcnt < 255) m_rstcnt++;
        m_cause = (m_cause & ~clr) | set;
        if (req) last_req = n;
        m_sys = ((n - last_req) >= ST);
        #1;
        chk("sys_reset_n", {31'b0, sys_rn}, {31'b0, m_sys});
        chk("wdt_reset_n", {31'b0, wdt_rn}, {31'b0, (n >= 2)});
    endtask

    task automatic rd32(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus32.rd = 1'b1; bus32.addr = a;
        #1;
        chk(tag, bus32.rdata, exp);
        bus32.rd = 1'b0; bus32.addr = '0;
    endtask

    task automatic wr32(input logic [4:0] a, input logic [31:0] d);
        bus32.wr = 1'b1; bus32.addr = a; bus32.wdata = d;
        step();
        bus32.wr = 1'b0; bus32.addr = '0; bus32.wdata = '0;
    endtask

    task automatic rd8(input string tag, input logic [4:0] a, input logic [7:0] exp);
        bus8.rd = 1'b1; bus8.addr = a;
        #1;
        chk(tag, {24'b0, bus8.rdata}, {24'b0, exp});
        bus8.rd = 1'b0; bus8.addr = '0;
    endtask

    task automatic wr8(input logic [4:0] a, input logic [7:0] d);
        bus8.wr = 1'b1; bus8.addr = a; bus8.wdata = d;
        step();
        bus8.wr = 1'b0; bus8.addr = '0; bus8.wdata = '0;
    endtask

    initial begin
        int ext_left;
        int unsigned op;

        reset_n = 1'b0; wdt_req = 1'b0; ext_n = 1'b1; wdt8 = 1'b0; ext8 = 1'b1;
        bus32.wr = 1'b0; bus32.rd = 1'b0; bus32.addr = '0; bus32.wdata = '0;
        bus8.wr  = 1'b0; bus8.rd  = 1'b0; bus8.addr  = '0; bus8.wdata  = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("por_sys", {31'b0, sys_rn}, 32'd0);
        chk("por_wdt", {31'b0, wdt_rn}, 32'd0);
        chk("rdata_idle", bus32.rdata, 32'd0);
        rd32("por_cause_in_reset", 5'h00, 32'h1);
        #2 reset_n = 1'b1;

        // Power-on: wdt at edge 2, sys at edge 18, checked per edge by step()
        repeat (20) step();
        rd32("por_cause", 5'h00, 32'h1);
        rd32("por_rstcnt", 5'h08, 32'h0);

        wdt_req = 1'b1; step(); wdt_req = 1'b0;
        repeat (20) step();
        rd32("wdt_cause", 5'h00, 32'h3);
        rd32("wdt_rstcnt", 5'h08, 32'h1);

        wr32(5'h04, 32'h12);
        repeat (3) step();
        wr32(5'h04, 32'hA5);
        repeat (20) step();
        rd32("sw_cause", 5'h00, 32'h7);
        rd32("sw_rstcnt", 5'h08, 32'h2);
        wr32(5'h00, 32'h4);
        rd32("w1c_cause", 5'h00, 32'h3);
        rd32("swrst_reads0", 5'h04, 32'h0);
        wr32(5'h0C, 32'hFFFF_FFFF);
        rd32("unmapped_reads0", 5'h0C, 32'h0);
        rd32("unmapped_wr_ignored", 5'h00, 32'h3);

        ext_n = 1'b0;
        repeat (40) step();
        ext_n = 1'b1;
        repeat (25) step();
        rd32("ext_rstcnt", 5'h08, 32'h3);
        rd32("ext_cause", 5'h00, 32'hB);

        wdt_req = 1'b1; step(); wdt_req = 1'b0;
        repeat (9) step();
        wdt_req = 1'b1;
        wr32(5'h00, 32'h2);
        wdt_req = 1'b0;
        repeat (30) step();
        rd32("set_wins_cause", 5'h00, 32'hB);
        rd32("reload_rstcnt", 5'h08, 32'h4);

        wr32(5'h08, 32'h0);
        rd32("rstcnt_clear", 5'h08, 32'h0);
        wdt_req = 1'b1;
        wr32(5'h08, 32'h0);
        wdt_req = 1'b0;
        rd32("rstcnt_inc_wins", 5'h08, 32'h1);
        repeat (20) step();

        ext_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (ext_left > 0) begin
                ext_left--;
                if (ext_left == 0) ext_n = 1'b1;
            end else if ($urandom_range(0, 99) < 2) begin
                ext_n    = 1'b0;
                ext_left = $urandom_range(1, 30);
            end
            wdt_req = ($urandom_range(0, 99) < 3);
            op = $urandom_range(0, 49);
            bus32.wr = (op <= 4);
            case (op)
                0:       begin bus32.addr = 5'h04; bus32.wdata = 32'hA5; end
                1:       begin bus32.addr = 5'h04; bus32.wdata = $urandom; end
                2, 3:    begin bus32.addr = 5'h00; bus32.wdata = $urandom_range(0, 15); end
                4:       begin bus32.addr = 5'h08; bus32.wdata = $urandom; end
                default: begin bus32.addr = '0;    bus32.wdata = '0; end
            endcase
            step();
            bus32.wr = 1'b0; wdt_req = 1'b0;
            rd32("rand_cause", 5'h00, {28'b0, m_cause});
            rd32("rand_rstcnt", 5'h08, 32'(m_rstcnt));
        end
        ext_n = 1'b1;
        repeat (40) step();

        // Asynchronous power-on reset in the middle of a HOLD
        wdt_req = 1'b1; step(); wdt_req = 1'b0;
        repeat (5) step();
        #1 reset_n = 1'b0;
        #1;
        chk("async_sys", {31'b0, sys_rn}, 32'd0);
        chk("async_wdt", {31'b0, wdt_rn}, 32'd0);
        rd32("async_cause", 5'h00, 32'h1);
        rd32("async_rstcnt", 5'h08, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        repeat (12) step();

        rd8("b8_cause0", 5'h00, 8'h01);
        rd8("b8_cause1", 5'h01, 8'h00);
        rd8("b8_cause2", 5'h02, 8'h00);
        rd8("b8_cause3", 5'h03, 8'h00);
        rd8("b8_rstcnt", 5'h08, 8'h00);
        chk("b8_sys_up", {31'b0, sys_rn8}, 32'd1);

        for (int i = 0; i < 256; i++) begin
            wdt8 = 1'b1; step(); wdt8 = 1'b0;
            chk("b8_sys_low", {31'b0, sys_rn8}, 32'd0);
            repeat (ST8) step();
            chk("b8_sys_high", {31'b0, sys_rn8}, 32'd1);
        end
        rd8("b8_rstcnt_sat", 5'h08, 8'hFF);
        rd8("b8_rstcnt_hi", 5'h09, 8'h00);
        rd8("b8_cause_wdt", 5'h00, 8'h03);
        wr8(5'h01, 8'hFF);
        rd8("b8_lane1_no_clr", 5'h00, 8'h03);
        wr8(5'h00, 8'h02);
        rd8("b8_w1c", 5'h00, 8'h01);
        wr8(5'h04, 8'hA5);
        chk("b8_sw_low", {31'b0, sys_rn8}, 32'd0);
        rd8("b8_swrst_reads0", 5'h04, 8'h00);
        repeat (ST8 + 2) step();
        rd8("b8_sw_cause", 5'h00, 8'h05);
        rd8("b8_rstcnt_still_sat", 5'h08, 8'hFF);
        wr8(5'h08, 8'h00);
        rd8("b8_rstcnt_clr", 5'h08, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ehl_rst_ctrl.md
# ehl_rst_ctrl

Reset controller that sits directly downstream of the watchdog timer. It consumes the watchdog's one-cycle `rst_req` pulse, an external reset pin and a keyed software request. It produces the two resets the watchdog consumes: `wdt_reset_n` (power-on only) and `sys_reset_n` (everything else), with a guaranteed minimum assertion width. Reset cause and a reset counter are kept in a small CSR window on the same 8/16/32-bit register bus used by the timer blocks.

## Interface
- `WIDTH`, 32, system bus width; legal values 8, 16, 32. Any other value aborts simulation with an error.
- `STRETCH`, 16, `sys_reset_n` low time in clk cycles; legal range 2..65535.
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: power-on reset, asynchronous, active-low. Asserts all outputs immediately.
- `wdt_rst_req` input 1: one-cycle reset request from the watchdog.
- `ext_rst_n` input 1: external reset pin, asynchronous to clk, active-low, level-sensitive.
- `wdt_reset_n` output 1: watchdog reset.
- `sys_reset_n` output 1: system reset. Feeds the watchdog `reset_n` and the rest of the SoC.
- `wr` input 1, `rd` input 1, `addr` input 5, `wdata` input WIDTH: register bus, sampled on clk.
- `rdata` output WIDTH: combinational; zero when `rd`=0.

## Operation
- `wdt_reset_n`: 2-flop synchroniser of `reset_n`. Asserts asynchronously; deasserts synchronously.
- `ext_rst_n`: 2-flop synchroniser, reset by `reset_n`, reset value 0. The synchronised level is `ext_req` = !sync.
- `sw_req`: a write to SWRST with byte0 == 8'hA5 produces a one-cycle pulse. Any other value is ignored.
- Any request = `wdt_rst_req | sw_req | ext_req`.
- FSM states:
  - HOLD (reset state): `sys_reset_n`=0. Counts only while `wdt_reset_n`=1.
  - RUN: `sys_reset_n`=1.
- RUN + any request → HOLD, with `cnt` loaded to STRETCH-1.
- In HOLD, any request reloads `cnt` to STRETCH-1. Held `ext_req` therefore keeps the system in reset until it is released.
- In HOLD with no request: if `cnt`==0 → RUN, else `cnt`-1.
- `cnt` is 16 bits. It never wraps below 0.
- `sys_reset_n` is a flop: (next state == RUN). It is never combinationally derived.
- CAUSE register, 4 bits: [0] POR, [1] WDT, [2] SW, [3] EXT.
  - Reset value 4'b0001.
  - A request sets its bit in every cycle it is active, in either state.
  - Write 1 clears the bit. Set wins over a same-cycle clear.
- RSTCNT register, 8 bits, reset 0. Increments on each RUN→HOLD transition and saturates at 8'hFF. Any write clears it; an increment in the same cycle wins (result 1).
- Only `reset_n` resets the CSRs. They survive `sys_reset_n`.
- CSR map (word offsets):
  - 0x00 CAUSE, RW1C.
  - 0x04 SWRST, WO, reads 0.
  - 0x08 RSTCNT, RW.
  - Other offsets read 0; writes to them are ignored.
- WIDTH < 32: `addr[1:0]` selects the byte (8-bit bus) or halfword (16-bit bus). Write strobes are generated per byte lane. Read data is the selected word shifted right by 8*lane.

## Timing
- Reset values: `wdt_reset_n`=0, `sys_reset_n`=0, `rdata`=0, CAUSE=4'b0001, RSTCNT=0, state HOLD, `cnt`=STRETCH-1.
- After `reset_n` rises, `wdt_reset_n` goes high after the 2nd rising clk edge.
- After that, `sys_reset_n` goes high exactly STRETCH edges later.
- `wdt_rst_req` sampled at edge E in RUN → `sys_reset_n` low after E, high again after edge E+STRETCH.
- `ext_rst_n` rise → `ext_req` drops 2 edges later. `sys_reset_n` rises STRETCH edges after that.
- `reset_n` asserted mid-HOLD or mid-RUN → immediate return to reset values. The CAUSE history is lost by design.

## Structure
- Package `ehl_rst_ctrl_pkg` holds:
  - CSR offset constants.
  - SWRST key 8'hA5.
  - CAUSE bit indices.
  - FSM state enum {HOLD, RUN}.
- Sub-module `ehl_rst_sync`: 2-flop async-assert/sync-deassert cell. It is instantiated for `reset_n`, and with the data input tied to `ext_rst_n` for the pin.

## Test plan
- Power-on, STRETCH=16: release `reset_n` → `wdt_reset_n` high at edge 2, `sys_reset_n` high at edge 18. CAUSE reads 0x1.
- In RUN, 1-cycle `wdt_rst_req` → `sys_reset_n` low for 16 cycles. CAUSE=0x3, RSTCNT=1. `wdt_reset_n` stays 1 throughout.
- Write 0x12 to SWRST → no reset. Write 0xA5 → 16-cycle reset, CAUSE bit2 set. Write 0x4 to CAUSE → CAUSE bit2 clears.
- Hold `ext_rst_n` low 40 cycles → `sys_reset_n` low until 2+16 cycles after release. RSTCNT increments by 1 only.
- `wdt_rst_req` at HOLD cycle 10 → counter reloads, total low time 26 cycles. CAUSE W1C of bit1 in the same cycle as a new WDT request → bit1 stays 1.
- WIDTH=8: read CAUSE bytes at addr 0..3 → 0x01,0,0,0. 256 watchdog resets → RSTCNT saturates at 0xFF.
